pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Program-counter generator directly upstream of the fetch stage. It drives the
//   fetch instruction address each cycle and selects the next PC by priority:
//   trap > jump > hold > sequential (+4).
//  Contains a boot FSM (ROM settle delay), halt/resume control, a misaligned-target
//   check and a count of executed instructions. Single clock domain.
// PARAMETERS
//  ADDR_W      32        PC width; matches `CpuWidth
//  RESET_VEC   32'h0     PC value loaded on reset
//  BOOT_CYCLES 2         cycles spent in BOOT before the first valid fetch (>=1)
// PORTS
//  clk_i          in   1       clock, rising edge
//  rst_i          in   1       synchronous reset, active-high
//  hold_i         in   1       stall: keep PC unchanged
//  jump_en_i      in   1       branch/jump redirect request
//  jump_addr_i    in   ADDR_W  redirect target
//  trap_en_i      in   1       trap entry request
//  trap_addr_i    in   ADDR_W  trap vector; bits[1:0] forced to 0 internally
//  halt_i         in   1       enter HALT at next edge (RUN only)
//  resume_i       in   1       leave HALT
//  instr_addr_o   out  ADDR_W  current PC -> fetch instr_addr_i
//  instr_valid_o  out  1       1 when instr_addr_o is an executed fetch (RUN, not hold)
//  misalign_o     out  1       1-cycle pulse: rejected jump target
//  misalign_addr_o out ADDR_W  last rejected target; holds until next reject or reset
//  state_o        out  2       00 RST, 01 BOOT, 10 RUN, 11 HALT
//  instr_cnt_o    out  32      count of cycles with instr_valid_o=1; wraps
// BEHAVIOUR
//  Reset (rst_i=1 at edge)
//   - Next-cycle values: pc=RESET_VEC, state=RST, boot counter=0, instr_cnt=0,
//     misalign_o=0, misalign_addr_o=0.
//   - Reset overrides every other input, in every state, including mid-HALT.
//  FSM
//   - RST -> BOOT unconditionally.
//   - BOOT counts BOOT_CYCLES cycles, then -> RUN.
//   - RUN -> HALT when halt_i=1.
//   - HALT -> RUN when resume_i=1.
//   - halt_i and resume_i both high in RUN: halt wins. In HALT: resume wins.
//  PC
//   - PC is held in RST, BOOT and HALT. instr_valid_o=0 in those states.
//   - instr_valid_o = (state==RUN) & ~hold_i. Combinational on hold_i.
//   - In RUN, the next PC is (first matching rule applies):
//       trap_en_i                  -> {trap_addr_i[ADDR_W-1:2],2'b00}
//       jump_en_i & target[1:0]==0 -> jump_addr_i
//       jump_en_i & target[1:0]!=0 -> PC held; misalign_o=1 next cycle;
//                                     misalign_addr_o<=jump_addr_i
//       hold_i                     -> PC held
//       otherwise                  -> PC+4, mod 2^ADDR_W
//         (0xFFFF_FFFC wraps to 0x0000_0000)
//   - trap/jump override hold_i: a redirect during a stall is not lost.
//   - The halt_i cycle still applies its PC update. HALT then freezes the PC.
//  Timing and counter
//   - Latency: a request at edge N is visible on instr_addr_o after edge N.
//     There is no combinational path from any input to instr_addr_o.
//   - instr_cnt_o increments at each edge where instr_valid_o=1.
// TESTING
//  1. Reset, RESET_VEC=0x100, BOOT_CYCLES=2 -> state 00,01,01,10.
//     First valid PC=0x100, then 0x104, 0x108.
//  2. RUN at PC=0x10; hold_i=1 for 3 cycles -> PC stays 0x10, valid=0,
//     instr_cnt frozen. Release -> 0x14.
//  3. jump_en_i with 0x200 and trap_en_i with 0x803 in the same cycle -> next PC=0x800.
//     jump alone with 0x200 under hold_i=1 -> next PC=0x200.
//  4. jump to 0x202 -> PC unchanged, misalign_o one-cycle pulse,
//     misalign_addr_o=0x202 held after the pulse.
//  5. PC=0xFFFFFFFC, no stall -> next PC=0x0. Also force instr_cnt=0xFFFFFFFF,
//     one valid cycle -> 0.
//  6. halt_i in RUN -> HALT, PC frozen. rst_i mid-HALT -> RST, PC=RESET_VEC,
//     cnt=0. resume_i while in BOOT -> ignored.

Source files
------------

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pc_gen
//  Brief    : Program-counter generator feeding the fetch stage. Boot delay,
//             halt/resume, trap/jump redirect, misaligned-target rejection
//             and an executed-instruction counter.
//  Revision : 1.0  initial release
// ============================================================================
module pc_gen #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
    parameter int                BOOT_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hold_i,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              trap_en_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    input  logic              halt_i,
    input  logic              resume_i,
    output logic [ADDR_W-1:0] instr_addr_o,
    output logic              instr_valid_o,
    output logic              misalign_o,
    output logic [ADDR_W-1:0] misalign_addr_o,
    output logic [1:0]        state_o,
    output logic [31:0]       instr_cnt_o
);

    localparam int                c_BOOT_W    = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [c_BOOT_W-1:0] c_BOOT_LAST = c_BOOT_W'(BOOT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] c_PC_STEP   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] c_ALIGN_MSK = ~ADDR_W'(3);

    typedef enum logic [1:0] {
        ST_RST  = 2'b00,
        ST_BOOT = 2'b01,
        ST_RUN  = 2'b10,
        ST_HALT = 2'b11
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_BOOT_W-1:0] r_boot_cnt;
    logic [c_BOOT_W-1:0] w_boot_cnt_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic                r_misalign;
    logic                w_misalign_nxt;
    logic [ADDR_W-1:0]   r_misalign_addr;
    logic [ADDR_W-1:0]   w_misalign_addr_nxt;
    logic [31:0]         r_instr_cnt;
    logic [31:0]         w_instr_cnt_nxt;
    logic                w_run;
    logic                w_valid;
    logic                w_jump_misaligned;

    assign w_run             = (r_state == ST_RUN);
    assign w_valid           = w_run & ~hold_i;
    assign w_jump_misaligned = (jump_addr_i[1:0] != 2'b00);

    // Next state; halt beats resume in RUN, resume is only honoured in HALT.
    always_comb begin
        w_state_nxt    = r_state;
        w_boot_cnt_nxt = r_boot_cnt;
        case (r_state)
            ST_RST: begin
                w_state_nxt    = ST_BOOT;
                w_boot_cnt_nxt = '0;
            end
            ST_BOOT: begin
                if (r_boot_cnt == c_BOOT_LAST) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_boot_cnt_nxt = r_boot_cnt + c_BOOT_W'(1);
                end
            end
            ST_RUN: begin
                if (halt_i) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (resume_i) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RST;
        endcase
    end

    // Next PC; redirects are evaluated before hold so a stalled redirect is kept.
    always_comb begin
        w_pc_nxt            = r_pc;
        w_misalign_nxt      = 1'b0;
        w_misalign_addr_nxt = r_misalign_addr;
        if (w_run) begin
            if (trap_en_i) begin
                w_pc_nxt = trap_addr_i & c_ALIGN_MSK;
            end else if (jump_en_i) begin
                if (w_jump_misaligned) begin
                    w_misalign_nxt      = 1'b1;
                    w_misalign_addr_nxt = jump_addr_i;
                end else begin
                    w_pc_nxt = jump_addr_i;
                end
            end else if (!hold_i) begin
                w_pc_nxt = r_pc + c_PC_STEP;
            end
        end
    end

    always_comb begin
        w_instr_cnt_nxt = r_instr_cnt;
        if (w_valid) begin
            w_instr_cnt_nxt = r_instr_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state         <= ST_RST;
            r_boot_cnt      <= '0;
            r_pc            <= RESET_VEC;
            r_misalign      <= 1'b0;
            r_misalign_addr <= '0;
            r_instr_cnt     <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_boot_cnt      <= w_boot_cnt_nxt;
            r_pc            <= w_pc_nxt;
            r_misalign      <= w_misalign_nxt;
            r_misalign_addr <= w_misalign_addr_nxt;
            r_instr_cnt     <= w_instr_cnt_nxt;
        end
    end

    assign instr_addr_o    = r_pc;
    assign instr_valid_o   = w_valid;
    assign misalign_o      = r_misalign;
    assign misalign_addr_o = r_misalign_addr;
    assign state_o         = r_state;
    assign instr_cnt_o     = r_instr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_gen
//  Brief    : Scoreboard bench for pc_gen: directed scenarios then random
//             traffic against a cycle-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_gen;

    localparam logic [31:0] c_RV   = 32'h100;
    localparam int          c_BOOT = 2;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1, hold_i = 1'b0, jump_en_i = 1'b0, trap_en_i = 1'b0;
    logic        halt_i = 1'b0, resume_i = 1'b0;
    logic [31:0] jump_addr_i = '0, trap_addr_i = '0;
    logic [31:0] instr_addr_o, misalign_addr_o, instr_cnt_o;
    logic        instr_valid_o, misalign_o;
    logic [1:0]  state_o;

    pc_gen #(.ADDR_W(32), .RESET_VEC(c_RV), .BOOT_CYCLES(c_BOOT)) dut (
        .clk_i(clk), .rst_i(rst_i), .hold_i(hold_i),
        .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .trap_en_i(trap_en_i), .trap_addr_i(trap_addr_i),
        .halt_i(halt_i), .resume_i(resume_i),
        .instr_addr_o(instr_addr_o), .instr_valid_o(instr_valid_o),
        .misalign_o(misalign_o), .misalign_addr_o(misalign_addr_o),
        .state_o(state_o), .instr_cnt_o(instr_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  st;
        logic        vld;
        logic [31:0] cnt;
        logic        mis;
        logic [31:0] maddr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: state as names 0..3, boot tracked as cycles remaining.
    int          m_state = 0;
    int          m_boot_left = 0;
    logic [31:0] m_pc = c_RV, m_cnt = '0, m_maddr = '0;
    logic        m_mis = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic h, input logic je, input logic [31:0] ja,
                        input logic te, input logic [31:0] ta, input logic hl, input logic rs);
        exp_t e;
        bit   fetching;
        rst_i = r; hold_i = h; jump_en_i = je; jump_addr_i = ja;
        trap_en_i = te; trap_addr_i = ta; halt_i = hl; resume_i = rs;
        if (r) begin
            m_state = 0; m_pc = c_RV; m_cnt = 0; m_mis = 0; m_maddr = 0;
        end else begin
            fetching = (m_state == 2) && !h;
            m_mis = 0;
            if (m_state == 0) begin
                m_state = 1;
                m_boot_left = c_BOOT;
            end else if (m_state == 1) begin
                m_boot_left = m_boot_left - 1;
                if (m_boot_left == 0) m_state = 2;
            end else if (m_state == 2) begin
                if (te)                  m_pc = (ta / 4) * 4;
                else if (je && ja % 4 == 0) m_pc = ja;
                else if (je) begin       m_mis = 1; m_maddr = ja; end
                else if (!h)             m_pc = m_pc + 32'd4;
                if (fetching) m_cnt = m_cnt + 1;
                if (hl) m_state = 3;
            end else begin
                if (rs) m_state = 2;
            end
        end
        e.pc = m_pc; e.st = 2'(m_state); e.vld = (m_state == 2) && !h;
        e.cnt = m_cnt; e.mis = m_mis; e.maddr = m_maddr;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares every queued expectation just after the edge it describes.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc",       instr_addr_o,          e.pc);
                chk("state",    32'(state_o),          32'(e.st));
                chk("valid",    32'(instr_valid_o),    32'(e.vld));
                chk("cnt",      instr_cnt_o,           e.cnt);
                chk("misalign", 32'(misalign_o),       32'(e.mis));
                chk("mis_addr", misalign_addr_o,       e.maddr);
            end
        end
    end

    initial begin
        logic [31:0] cnt_before;
        logic [31:0] ja;
        // Boot sequence
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("t1_rst_state", 32'(state_o), 32'h0);
        chk("t1_rst_pc", instr_addr_o, c_RV);
        idle();
        chk("t1_boot0", 32'(state_o), 32'h1);
        idle();
        chk("t1_boot1", 32'(state_o), 32'h1);
        idle();
        chk("t1_run", 32'(state_o), 32'h2);
        chk("t1_pc0", instr_addr_o, 32'h100);
        idle();
        idle();
        chk("t1_pc2", instr_addr_o, 32'h108);
        chk("t1_cnt", instr_cnt_o, 32'd2);
        // Hold
        step(0, 0, 1, 32'h10, 0, 0, 0, 0);
        cnt_before = instr_cnt_o;
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("t2_hold_pc", instr_addr_o, 32'h10);
        chk("t2_hold_vld", 32'(instr_valid_o), 32'h0);
        chk("t2_hold_cnt", instr_cnt_o, cnt_before);
        idle();
        chk("t2_release", instr_addr_o, 32'h14);
        // Trap over jump, jump over hold
        step(0, 0, 1, 32'h200, 1, 32'h803, 0, 0);
        chk("t3_trap", instr_addr_o, 32'h800);
        step(0, 1, 1, 32'h200, 0, 0, 0, 0);
        chk("t3_jump_hold", instr_addr_o, 32'h200);
        // Misaligned target
        step(0, 0, 1, 32'h202, 0, 0, 0, 0);
        chk("t4_pc_kept", instr_addr_o, 32'h200);
        chk("t4_pulse", 32'(misalign_o), 32'h1);
        idle();
        chk("t4_pulse_end", 32'(misalign_o), 32'h0);
        chk("t4_addr_held", misalign_addr_o, 32'h202);
        // PC wrap
        step(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        idle();
        chk("t5_wrap", instr_addr_o, 32'h0);
        // Halt, reset mid-halt, resume during boot
        step(0, 0, 0, 0, 0, 0, 1, 0);
        chk("t6_halt", 32'(state_o), 32'h3);
        chk("t6_halt_pc", instr_addr_o, 32'h4);
        idle();
        idle();
        chk("t6_frozen", instr_addr_o, 32'h4);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        chk("t6_rst_pc", instr_addr_o, c_RV);
        chk("t6_rst_cnt", instr_cnt_o, 32'h0);
        idle();
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("t6_boot_resume", 32'(state_o), 32'h1);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            ja = $urandom;
            if ($urandom_range(3) != 0) ja[1:0] = 2'b00;
            step($urandom_range(63) == 0, $urandom_range(3) == 0,
                 $urandom_range(5) == 0, ja,
                 $urandom_range(15) == 0, $urandom,
                 $urandom_range(15) == 0, $urandom_range(3) == 0);
        end
        idle();
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
